// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter sharing one valid/ready memory slave bus.
// Optional MEM_ARB_TIMEOUT_EN terminates transfers that never see s_ready.
//
// state | meaning
// IDLE  | no grant active; arbitrate pending requests
// BUSY  | slave bus driven by the granted master until completion
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic        owner,
   output logic        bus_err,
   output logic [31:0] bus_err_addr
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t state_q, state_d;
   logic   owner_q, owner_d;
   logic   last_q, last_d;
   logic   own_valid;
   logic   done;
   logic   timeout;

   assign own_valid = owner_q ? m1_valid : m0_valid;
   assign s_instr   = owner_q ? m1_instr : m0_instr;
   assign s_addr    = owner_q ? m1_addr  : m0_addr;
   assign s_wdata   = owner_q ? m1_wdata : m0_wdata;
   assign s_wstrb   = owner_q ? m1_wstrb : m0_wstrb;
   assign owner     = owner_q;

   assign m0_ready = done & ~owner_q;
   assign m1_ready = done &  owner_q;
   assign m0_rdata = timeout ? ERR_RDATA : s_rdata;
   assign m1_rdata = timeout ? ERR_RDATA : s_rdata;
   assign bus_err  = timeout;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   err_addr_q, err_addr_d;

   // s_ready deliberately gates the timeout so a late ready still completes normally
   assign timeout = (state_q == BUSY) & own_valid & ~s_ready &
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign bus_err_addr = err_addr_q;

   always_comb begin
      cnt_d      = cnt_q;
      err_addr_d = err_addr_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (!s_ready) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (timeout) begin
         err_addr_d = s_addr;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q      <= '0;
         err_addr_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         err_addr_q <= err_addr_d;
      end
   end
`else
   logic [31:0] unused_timeout_cfg;

   assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
   assign timeout            = 1'b0;
   assign bus_err_addr       = '0;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      s_valid = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_valid | m1_valid) begin
               state_d = BUSY;
               if (m0_valid & m1_valid) begin
                  owner_d = ~last_q;
               end else begin
                  owner_d = m1_valid;
               end
            end
         end
         BUSY: begin
            s_valid = own_valid & ~timeout;
            // a master withdrawing its request just releases the bus silently
            if (!own_valid) begin
               state_d = IDLE;
            end else if (s_ready | timeout) begin
               done    = 1'b1;
               last_d  = owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: scripted masters and slave, a grant-level
// reference model checked every cycle, plus literal expectations per scenario.
module tb_mem_bus_arbiter;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int          TO_CYC  = 16;
   localparam logic [31:0] ERR_VAL = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        m0_valid, m0_instr, m0_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_wstrb;
   logic        m1_valid, m1_instr, m1_ready;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        s_valid, s_instr, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic        owner, bus_err;
   logic [31:0] bus_err_addr;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .ERR_RDATA(ERR_VAL)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .owner(owner), .bus_err(bus_err), .bus_err_addr(bus_err_addr)
   );

   typedef struct {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          hold;   // 0: hold until ready, k: withdraw after k valid cycles
   } req_t;

   typedef struct {
      int          who;
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          cyc;
   } done_t;

   req_t  q0[$], q1[$];
   req_t  mr[2];
   req_t  idle_req;
   bit    mv[2];
   int    vcnt[2];
   bit    rdy_seen[2];
   done_t log_q[$];

   bit          rst_req;
   int          slave_lat;
   bit          slave_hang;
   logic [31:0] slave_rdata;
   int          sv_cnt;
   int          cyc;

   logic        obs_s_valid, obs_m0_ready, obs_m1_ready, obs_owner, obs_bus_err;
   logic [31:0] obs_s_addr, obs_m0_rdata, obs_m1_rdata, obs_err_addr;

   // reference model: who holds the bus, who was served last, how long the grant has lasted
   bit          md_busy;
   int          md_owner;
   int          md_last;
   int          md_age;
   logic [31:0] md_eaddr;

   int n_cmp = 0;
   int n_bad = 0;

   assign m0_valid = mv[0];
   assign m0_instr = mr[0].instr;
   assign m0_addr  = mr[0].addr;
   assign m0_wdata = mr[0].wdata;
   assign m0_wstrb = mr[0].wstrb;
   assign m1_valid = mv[1];
   assign m1_instr = mr[1].instr;
   assign m1_addr  = mr[1].addr;
   assign m1_wdata = mr[1].wdata;
   assign m1_wstrb = mr[1].wstrb;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int m, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input int hold);
      req_t r;
      r.instr = instr; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb; r.hold = hold;
      if (m == 0) q0.push_back(r);
      else        q1.push_back(r);
   endtask

   task automatic check_model();
      bit          own_v, tmo, exp_sv;
      bit          exp_rdy[2];
      logic [31:0] exp_rdata;
      if (!resetn) begin
         md_busy = 0; md_owner = 0; md_last = 1; md_age = 0; md_eaddr = '0;
      end
      own_v = 0; tmo = 0; exp_sv = 0;
      exp_rdy[0] = 0; exp_rdy[1] = 0;
      exp_rdata = s_rdata;
      if (resetn && md_busy) begin
         own_v = mv[md_owner];
         tmo = TO_EN && own_v && !s_ready && (md_age == TO_CYC - 1);
         exp_sv = own_v && !tmo;
         exp_rdy[md_owner] = (own_v && s_ready) || tmo;
         if (tmo) exp_rdata = ERR_VAL;
      end
      chk("s_valid", s_valid, exp_sv);
      chk("m0_ready", m0_ready, exp_rdy[0]);
      chk("m1_ready", m1_ready, exp_rdy[1]);
      chk("owner", owner, 32'(md_owner));
      chk("bus_err", bus_err, tmo);
      chk("bus_err_addr", bus_err_addr, md_eaddr);
      if (exp_sv) begin
         chk("s_addr", s_addr, mr[md_owner].addr);
         chk("s_wdata", s_wdata, mr[md_owner].wdata);
         chk("s_wstrb", s_wstrb, mr[md_owner].wstrb);
         chk("s_instr", s_instr, mr[md_owner].instr);
      end
      if (exp_rdy[0]) chk("m0_rdata", m0_rdata, exp_rdata);
      if (exp_rdy[1]) chk("m1_rdata", m1_rdata, exp_rdata);
      if (resetn) begin
         if (!md_busy) begin
            if (mv[0] || mv[1]) begin
               md_busy  = 1;
               md_age   = 0;
               md_owner = (mv[0] && mv[1]) ? 1 - md_last : (mv[0] ? 0 : 1);
            end
         end else if (!own_v) begin
            md_busy = 0;
         end else if (exp_rdy[md_owner]) begin
            md_busy = 0;
            md_last = md_owner;
            if (tmo) md_eaddr = mr[md_owner].addr;
         end else begin
            md_age++;
         end
      end
   endtask

   // one bus cycle: drive at negedge, slave answers 1ns later, sample 1ns before posedge
   task automatic cycle();
      done_t d;
      @(negedge clk);
      resetn = rst_req;
      if (!rst_req) begin
         q0.delete(); q1.delete();
         rdy_seen[0] = 0; rdy_seen[1] = 0;
         vcnt[0] = 0; vcnt[1] = 0;
      end
      if (rdy_seen[0] || (mv[0] && mr[0].hold > 0 && vcnt[0] >= mr[0].hold)) begin
         if (q0.size() > 0) q0.delete(0);
         vcnt[0] = 0;
      end
      if (rdy_seen[1] || (mv[1] && mr[1].hold > 0 && vcnt[1] >= mr[1].hold)) begin
         if (q1.size() > 0) q1.delete(0);
         vcnt[1] = 0;
      end
      rdy_seen[0] = 0; rdy_seen[1] = 0;
      mv[0] = q0.size() > 0;
      mr[0] = mv[0] ? q0[0] : idle_req;
      mv[1] = q1.size() > 0;
      mr[1] = mv[1] ? q1[0] : idle_req;
      s_ready = 1'b0;
      s_rdata = slave_rdata;
      #1;
      s_ready = s_valid && !slave_hang && (sv_cnt >= slave_lat);
      #3;
      obs_s_valid = s_valid; obs_s_addr = s_addr;
      obs_m0_ready = m0_ready; obs_m1_ready = m1_ready;
      obs_m0_rdata = m0_rdata; obs_m1_rdata = m1_rdata;
      obs_owner = owner; obs_bus_err = bus_err; obs_err_addr = bus_err_addr;
      check_model();
      if (m0_ready || m1_ready) begin
         d.who = m1_ready ? 1 : 0;
         d.rdata = m1_ready ? m1_rdata : m0_rdata;
         d.addr = s_addr; d.wdata = s_wdata; d.wstrb = s_wstrb; d.cyc = cyc;
         log_q.push_back(d);
      end
      rdy_seen[0] = m0_ready; rdy_seen[1] = m1_ready;
      if (mv[0]) vcnt[0]++;
      if (mv[1]) vcnt[1]++;
      if (s_valid && !s_ready) sv_cnt++;
      else                     sv_cnt = 0;
      cyc++;
      @(posedge clk);
   endtask

   task automatic drain(input int max, input string nm);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < max) begin
         cycle();
         n++;
      end
      if (q0.size() > 0 || q1.size() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: requests still pending after %0d cycles, required none", nm, max);
      end
   endtask

   function automatic int log_who(input int idx);
      return (idx < log_q.size()) ? log_q[idx].who : -1;
   endfunction

   function automatic int log_cyc(input int idx);
      return (idx < log_q.size()) ? log_q[idx].cyc : -1000;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  base;
      bit  any_rdy;
      idle_req.instr = 0; idle_req.addr = '0; idle_req.wdata = '0;
      idle_req.wstrb = '0; idle_req.hold = 0;
      mv[0] = 0; mv[1] = 0; mr[0] = idle_req; mr[1] = idle_req;
      vcnt[0] = 0; vcnt[1] = 0; rdy_seen[0] = 0; rdy_seen[1] = 0;
      rst_req = 0; slave_lat = 0; slave_hang = 0; slave_rdata = '0;
      sv_cnt = 0; cyc = 0; s_ready = 0; s_rdata = '0;
      md_busy = 0; md_owner = 0; md_last = 1; md_age = 0; md_eaddr = '0;

      cycle(); cycle();
      chk("rst_owner", obs_owner, 0);
      chk("rst_s_valid", obs_s_valid, 0);
      chk("rst_err_addr", obs_err_addr, 0);
      rst_req = 1;
      cycle();

      // single m0 read, slave answers on the third bus cycle
      slave_lat = 2; slave_rdata = 32'h1234_5678;
      push(0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 0);
      cycle(); chk("t1_arb_cycle_s_valid", obs_s_valid, 0);
      cycle(); chk("t1_s_valid", obs_s_valid, 1); chk("t1_s_addr", obs_s_addr, 32'h0000_0010);
      cycle(); chk("t1_wait_ready", obs_m0_ready, 0);
      cycle(); chk("t1_ready", obs_m0_ready, 1); chk("t1_rdata", obs_m0_rdata, 32'h1234_5678);
      cycle(); chk("t1_pulse_width", obs_m0_ready, 0);

      // fresh reset, then simultaneous requests: m0 first, m1 after one idle cycle
      rst_req = 0; cycle(); rst_req = 1; cycle();
      slave_lat = 0; slave_rdata = 32'hA5A5_0001;
      base = log_q.size();
      push(0, 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 0);
      push(1, 1'b1, 32'h0000_0200, 32'h0, 4'b0000, 0);
      drain(20, "t2_drain");
      chk("t2_count", log_q.size() - base, 2);
      chk("t2_first", log_who(base), 0);
      chk("t2_second", log_who(base + 1), 1);
      chk("t2_gap", log_cyc(base + 1) - log_cyc(base), 2);

      // both masters keep requesting: grants alternate, m1 write passes through
      base = log_q.size();
      push(0, 1'b0, 32'h0000_0300, 32'h0, 4'b0000, 0);
      push(0, 1'b0, 32'h0000_0304, 32'h0, 4'b0000, 0);
      push(1, 1'b0, 32'h2000_0004, 32'hCAFE_F00D, 4'b0011, 0);
      push(1, 1'b0, 32'h2000_0008, 32'h1111_2222, 4'b1111, 0);
      drain(40, "t3_drain");
      chk("t3_count", log_q.size() - base, 4);
      chk("t3_g0", log_who(base), 0);
      chk("t3_g1", log_who(base + 1), 1);
      chk("t3_g2", log_who(base + 2), 0);
      chk("t3_g3", log_who(base + 3), 1);
      if (log_q.size() > base + 1) begin
         chk("t3_w_addr", log_q[base + 1].addr, 32'h2000_0004);
         chk("t3_w_wstrb", log_q[base + 1].wstrb, 4'b0011);
         chk("t3_w_wdata", log_q[base + 1].wdata, 32'hCAFE_F00D);
      end

      // reset while m1 holds the bus
      slave_hang = 1;
      base = log_q.size();
      push(1, 1'b0, 32'h3000_0000, 32'h5555_AAAA, 4'b1111, 0);
      cycle(); cycle(); cycle();
      chk("t4_busy_owner", obs_owner, 1);
      chk("t4_busy_s_valid", obs_s_valid, 1);
      rst_req = 0; cycle();
      chk("t4_rst_s_valid", obs_s_valid, 0);
      chk("t4_rst_m1_ready", obs_m1_ready, 0);
      chk("t4_rst_owner", obs_owner, 0);
      rst_req = 1; slave_hang = 0; cycle();
      chk("t4_post_owner", obs_owner, 0);
      chk("t4_post_s_valid", obs_s_valid, 0);
      chk("t4_no_completion", log_q.size() - base, 0);

`ifdef MEM_ARB_TIMEOUT_EN
      // unmapped address: forced termination on the 16th busy cycle
      slave_hang = 1;
      push(0, 1'b0, 32'h5000_0000, 32'h0, 4'b0000, 0);
      cycle();
      any_rdy = 0;
      for (int k = 0; k < 15; k++) begin
         cycle();
         any_rdy = any_rdy | obs_m0_ready | obs_bus_err;
      end
      chk("t5_early_term", any_rdy, 0);
      cycle();
      chk("t5_ready", obs_m0_ready, 1);
      chk("t5_bus_err", obs_bus_err, 1);
      chk("t5_err_rdata", obs_m0_rdata, 32'hFFFF_FFFF);
      chk("t5_s_valid_forced", obs_s_valid, 0);
      slave_hang = 0;
      cycle();
      chk("t5_err_pulse", obs_bus_err, 0);
      chk("t5_err_addr", obs_err_addr, 32'h5000_0000);
      slave_rdata = 32'h0BAD_CAFE;
      base = log_q.size();
      push(1, 1'b0, 32'h0000_0600, 32'h0, 4'b0000, 0);
      drain(20, "t5_drain");
      chk("t5_next_owner", log_who(base), 1);
      if (log_q.size() > base) chk("t5_next_rdata", log_q[base].rdata, 32'h0BAD_CAFE);
`endif

      // owner withdraws mid-transfer: bus released without ready or error
      slave_hang = 1;
      base = log_q.size();
      push(0, 1'b0, 32'h0000_0400, 32'h0, 4'b0000, 3);
      cycle(); cycle(); cycle();
      chk("t6_busy", obs_s_valid, 1);
      cycle();
      chk("t6_drop_s_valid", obs_s_valid, 0);
      chk("t6_drop_ready", obs_m0_ready, 0);
      chk("t6_drop_err", obs_bus_err, 0);
      cycle();
      chk("t6_idle", obs_s_valid, 0);
      chk("t6_no_completion", log_q.size() - base, 0);
      slave_hang = 0; slave_rdata = 32'h7777_0404;
      push(1, 1'b0, 32'h0000_0404, 32'h0, 4'b0000, 0);
      drain(20, "t6_drain");
      chk("t6_after_owner", log_who(base), 1);
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
